enemy_control: RTL and testbench



---
 rtl/enemy_control.sv | 144 ++++++++++++++
 tb/tb_enemy_control.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/enemy_control.sv
// Frame sequencer driving the enemy block's one-hot phase strobes from a free-running frame timer.
// Optional draw watchdog enabled by defining ENEMY_CONTROL_DRAW_TIMEOUT_EN.
module enemy_control #(
  parameter int unsigned FRAME_CYCLES   = 833333,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        draw_done,
  output logic        init,
  output logic        idle,
  output logic        gen_move,
  output logic        apply_move,
  output logic        draw,
  output logic [15:0] frame_count,
  output logic        frame_overrun,
  output logic        draw_timeout
);

  localparam int unsigned TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  if (FRAME_CYCLES < 16 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("enemy_control: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_GEN, S_SETTLE, S_APPLY, S_DRAW
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          pending_q, pending_d;
  logic [3:0]    settle_q, settle_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          overrun_q, overrun_d;
  logic          tick;
  logic          in_frame;
  logic          wd_expire;

  assign tick     = (tick_cnt_q == TW'(FRAME_CYCLES - 1));
  assign in_frame = (state_q == S_GEN) || (state_q == S_SETTLE) ||
                    (state_q == S_APPLY) || (state_q == S_DRAW);

`ifdef ENEMY_CONTROL_DRAW_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Watchdog sits at zero outside DRAW, which is the same as clearing on entry.
  always_comb begin
    wd_d      = (state_q == S_DRAW) ? wd_q + 16'd1 : '0;
    wd_expire = (state_q == S_DRAW) && (wd_q == 16'(TIMEOUT_CYCLES - 1));
    timeout_d = wd_expire && !draw_done;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign draw_timeout = timeout_q;
`else
  assign wd_expire    = 1'b0;
  assign draw_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_INIT;
      tick_cnt_q  <= '0;
      pending_q   <= 1'b0;
      settle_q    <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      pending_q   <= pending_d;
      settle_q    <= settle_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   if (start) state_d = S_IDLE;
      S_IDLE:   if ((tick || pending_q) && !pause) state_d = S_GEN;
      S_GEN:    state_d = S_SETTLE;
      S_SETTLE: if (settle_q == '0) state_d = S_APPLY;
      S_APPLY:  state_d = S_DRAW;
      S_DRAW:   if (draw_done || wd_expire) state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  // A tick that cannot start a frame right now is remembered in one pending bit.
  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    pending_d   = pending_q;
    if (tick && (in_frame || (state_q == S_IDLE && pause)))
      pending_d = 1'b1;
    else if (state_q == S_IDLE && state_d == S_GEN)
      pending_d = 1'b0;
    settle_d    = settle_q;
    if (state_q == S_GEN)
      settle_d = 4'(SETTLE_CYCLES - 1);
    else if (state_q == S_SETTLE && settle_q != '0)
      settle_d = settle_q - 4'd1;
    frame_cnt_d = frame_cnt_q;
    if (state_q == S_DRAW && draw_done)
      frame_cnt_d = frame_cnt_q + 16'd1;
    overrun_d   = tick && in_frame;
  end

  always_comb begin
    init       = 1'b0;
    idle       = 1'b0;
    gen_move   = 1'b0;
    apply_move = 1'b0;
    draw       = 1'b0;
    unique case (state_q)
      S_INIT:   init       = 1'b1;
      S_IDLE:   idle       = 1'b1;
      S_GEN:    gen_move   = 1'b1;
      S_APPLY:  apply_move = 1'b1;
      S_DRAW:   draw       = 1'b1;
      default:  ;
    endcase
  end

  assign frame_count   = frame_cnt_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_enemy_control.sv
// Scoreboard bench for enemy_control: per-cycle expected output vectors queued by scenario.
// Covers both builds of ENEMY_CONTROL_DRAW_TIMEOUT_EN.
module tb_enemy_control;
  localparam int unsigned FC = 20;
  localparam int unsigned SC = 2;
  localparam int unsigned TC = 8;

  localparam logic [4:0] P_INIT = 5'b10000;
  localparam logic [4:0] P_IDLE = 5'b01000;
  localparam logic [4:0] P_GEN  = 5'b00100;
  localparam logic [4:0] P_SET  = 5'b00000;
  localparam logic [4:0] P_APP  = 5'b00010;
  localparam logic [4:0] P_DRAW = 5'b00001;

  logic        clock = 1'b0;
  logic        reset, start, pause, draw_done;
  logic        init, idle, gen_move, apply_move, draw;
  logic [15:0] frame_count;
  logic        frame_overrun, draw_timeout;

  enemy_control #(
    .FRAME_CYCLES(FC),
    .SETTLE_CYCLES(SC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .draw_done(draw_done),
    .init(init), .idle(idle), .gen_move(gen_move), .apply_move(apply_move), .draw(draw),
    .frame_count(frame_count), .frame_overrun(frame_overrun), .draw_timeout(draw_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [22:0] vec;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  task automatic check_eq(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Vector layout: {init,idle,gen_move,apply_move,draw, frame_count, frame_overrun, draw_timeout}
  function automatic void expect_range(input string tag, input int a, input int b,
                                       input logic [4:0] ph, input logic [15:0] fc,
                                       input logic ov, input logic to);
    for (int c = a; c <= b; c++) sb_q.push_back(exp_t'{c, {ph, fc, ov, to}, tag});
  endfunction

  task automatic drive_inputs();
    reset     = (cyc == 105) || (cyc == 127);
    start     = (cyc == 3) || (cyc == 106);
    pause     = (cyc >= 38) && (cyc <= 44);
    draw_done = (cyc == 28) || (cyc == 79);
  endtask

  task automatic monitor();
    logic [22:0] obs;
    exp_t        e;
    obs = {init, idle, gen_move, apply_move, draw, frame_count, frame_overrun, draw_timeout};
    check_eq("onehot", 23'($countones(obs[22:18]) <= 1), 23'd1);
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.cyc < cyc) check_eq({e.tag, "_missed"}, 23'(cyc), 23'(e.cyc));
      else             check_eq(e.tag, obs, e.vec);
    end
  endtask

  task automatic run_to(input int last);
    while (cyc <= last) begin
      drive_inputs();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; draw_done = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    cyc = 0;

    // Startup and first frame: tick at 19, draw_done sampled at 28.
    expect_range("reset_init", 0, 3,  P_INIT, 16'd0, 1'b0, 1'b0);
    expect_range("idle_wait",  4, 19, P_IDLE, 16'd0, 1'b0, 1'b0);
    expect_range("gen1",       20, 20, P_GEN,  16'd0, 1'b0, 1'b0);
    expect_range("settle1",    21, 22, P_SET,  16'd0, 1'b0, 1'b0);
    expect_range("apply1",     23, 23, P_APP,  16'd0, 1'b0, 1'b0);
    expect_range("draw1",      24, 28, P_DRAW, 16'd0, 1'b0, 1'b0);
    expect_range("done1",      29, 29, P_IDLE, 16'd1, 1'b0, 1'b0);
    run_to(29);

    // Pause held over the tick at 39; frame starts from pending at 46.
    expect_range("paused",     30, 45, P_IDLE, 16'd1, 1'b0, 1'b0);
    expect_range("gen_pend",   46, 46, P_GEN,  16'd1, 1'b0, 1'b0);
    expect_range("settle2",    47, 48, P_SET,  16'd1, 1'b0, 1'b0);
    expect_range("apply2",     49, 49, P_APP,  16'd1, 1'b0, 1'b0);
    run_to(49);

    // Long draw across ticks 59 and 79; exit at 79 coincides with a tick.
    expect_range("draw_long",  50, 59, P_DRAW, 16'd1, 1'b0, 1'b0);
    expect_range("overrun1",   60, 60, P_DRAW, 16'd1, 1'b1, 1'b0);
    expect_range("draw_long2", 61, 79, P_DRAW, 16'd1, 1'b0, 1'b0);
    expect_range("overrun2",   80, 80, P_IDLE, 16'd2, 1'b1, 1'b0);
    expect_range("gen_after",  81, 81, P_GEN,  16'd2, 1'b0, 1'b0);
    expect_range("settle3",    82, 83, P_SET,  16'd2, 1'b0, 1'b0);
    expect_range("apply3",     84, 84, P_APP,  16'd2, 1'b0, 1'b0);
    run_to(84);

    // draw_done never returned; reset lands in DRAW at 105.
`ifdef ENEMY_CONTROL_DRAW_TIMEOUT_EN
    expect_range("draw_wd",    85, 92,  P_DRAW, 16'd2, 1'b0, 1'b0);
    expect_range("timeout",    93, 93,  P_IDLE, 16'd2, 1'b0, 1'b1);
    expect_range("idle_to",    94, 99,  P_IDLE, 16'd2, 1'b0, 1'b0);
    expect_range("gen4",       100, 100, P_GEN,  16'd2, 1'b0, 1'b0);
    expect_range("settle4",    101, 102, P_SET,  16'd2, 1'b0, 1'b0);
    expect_range("apply4",     103, 103, P_APP,  16'd2, 1'b0, 1'b0);
    expect_range("draw4",      104, 105, P_DRAW, 16'd2, 1'b0, 1'b0);
`else
    expect_range("draw_hold",  85, 99,  P_DRAW, 16'd2, 1'b0, 1'b0);
    expect_range("overrun3",   100, 100, P_DRAW, 16'd2, 1'b1, 1'b0);
    expect_range("draw_hold2", 101, 105, P_DRAW, 16'd2, 1'b0, 1'b0);
`endif
    expect_range("rst_draw",   106, 106, P_INIT, 16'd0, 1'b0, 1'b0);
    run_to(106);

    // Restart, then reset during SETTLE: no apply strobe follows.
    expect_range("idle5",      107, 125, P_IDLE, 16'd0, 1'b0, 1'b0);
    expect_range("gen5",       126, 126, P_GEN,  16'd0, 1'b0, 1'b0);
    expect_range("settle5",    127, 127, P_SET,  16'd0, 1'b0, 1'b0);
    expect_range("rst_settle", 128, 131, P_INIT, 16'd0, 1'b0, 1'b0);
    run_to(131);

    check_eq("sb_leftover", 23'(sb_q.size()), 23'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
